// File: rtl/dmem_bus_pkg.sv
// Shared state encoding and constants for the data-memory bus controller.
package dmem_bus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  // Byte-offset address bits forced to zero on the word-wide bus.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Saturating cycle counter for an in-flight bus transaction.
// expired_o marks the last allowed REQ/WAIT cycle, so the FSM leaves after exactly TIMEOUT_CYCLES cycles.
module dmem_timeout_ctr
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Single-outstanding data-memory bus controller between the memory stage and a valid/ready bus.
// Stalls the pipeline from request until DONE (2 cycles fast path, 3 minimum otherwise); request fields held stable until handshake.
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [3:0]        mask,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              data_valid,
  output logic [31:0]       load_data,
  output logic              bus_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_mask,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data
);

  localparam logic [ADDR_W-1:0] ALIGN_KEEP = ~{{(ADDR_W-2){1'b0}}, WORD_ALIGN_MASK};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;
  logic              ctr_clr, ctr_en, expired;

  assign ctr_clr = (state_q == IDLE) && request;
  assign ctr_en  = (state_q == REQ) || (state_q == WAIT);

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    mask_d        = mask_q;
    wdata_d       = wdata_q;
    load_data_d   = load_data_q;
    bus_err_d     = bus_err_q;
    stall         = 1'b0;
    data_valid    = 1'b0;
    bus_req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        stall = request;
        if (request) begin
          addr_d  = address & ALIGN_KEEP;
          we_d    = we_re;
          mask_d  = mask;
          wdata_d = store_data;
          state_d = REQ;
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready && bus_rsp_valid) begin
          if (!we_q) load_data_d = bus_rsp_data;
          state_d = DONE;
        end else if (expired) begin
          load_data_d = '0;
          bus_err_d   = 1'b1;
          state_d     = DONE;
        end else if (bus_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A response on the final allowed cycle still counts as completion.
        if (bus_rsp_valid) begin
          if (!we_q) load_data_d = bus_rsp_data;
          state_d = DONE;
        end else if (expired) begin
          load_data_d = '0;
          bus_err_d   = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        data_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_mask  = mask_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Cycle-by-cycle directed bench: each row drives one cycle of inputs and states every expected output.
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        request, we_re, bus_req_ready, bus_rsp_valid;
  logic [3:0]  mask;
  logic [31:0] address, store_data, bus_rsp_data;
  logic        stall, data_valid, bus_err, bus_req_valid, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] req, we, msk, addr, sd, rdy, rv, rd;
    logic [31:0] e_stall, e_dv, e_ld, e_err, e_rqv, e_baddr, e_bwe, e_bmask, e_bwd;
  } vec_t;

  vec_t tbl[$];

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES(8),
    .ADDR_W        (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .we_re        (we_re),
    .mask         (mask),
    .address      (address),
    .store_data   (store_data),
    .stall        (stall),
    .data_valid   (data_valid),
    .load_data    (load_data),
    .bus_err      (bus_err),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_mask     (bus_mask),
    .bus_wdata    (bus_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data (bus_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [31:0] req, we, msk, addr, sd, rdy, rv, rd,
    input logic [31:0] st, dv, ld, err, rqv, ba, bwe, bm, bwd);
    vec_t v;
    v.req = req; v.we = we; v.msk = msk; v.addr = addr; v.sd = sd;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_stall = st; v.e_dv = dv; v.e_ld = ld; v.e_err = err; v.e_rqv = rqv;
    v.e_baddr = ba; v.e_bwe = bwe; v.e_bmask = bm; v.e_bwd = bwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, check settled outputs at the falling edge, then advance past the rising edge.
  task automatic apply_row(input string tag, input vec_t v);
    request       = v.req[0];
    we_re         = v.we[0];
    mask          = v.msk[3:0];
    address       = v.addr;
    store_data    = v.sd;
    bus_req_ready = v.rdy[0];
    bus_rsp_valid = v.rv[0];
    bus_rsp_data  = v.rd;
    @(negedge clk);
    chk({tag, ".stall"},     32'(stall),         v.e_stall);
    chk({tag, ".data_valid"}, 32'(data_valid),   v.e_dv);
    chk({tag, ".load_data"}, load_data,          v.e_ld);
    chk({tag, ".bus_err"},   32'(bus_err),       v.e_err);
    chk({tag, ".req_valid"}, 32'(bus_req_valid), v.e_rqv);
    chk({tag, ".bus_addr"},  bus_addr,           v.e_baddr);
    chk({tag, ".bus_we"},    32'(bus_we),        v.e_bwe);
    chk({tag, ".bus_mask"},  32'(bus_mask),      v.e_bmask);
    chk({tag, ".bus_wdata"}, bus_wdata,          v.e_bwd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //        req we msk  addr       sd            rdy rv rd             st dv ld            err rqv baddr      bwe bm    bwd
    // load, minimum latency
    tbl.push_back(mk(1, 0, 4'hC, 32'h1006, 0,            0, 0, 0,            1, 0, 0,            0, 0, 0,          0, 0,    0));
    tbl.push_back(mk(1, 0, 4'hC, 32'h1006, 0,            1, 0, 0,            1, 0, 0,            0, 1, 32'h1004,   0, 4'hC, 0));
    tbl.push_back(mk(1, 0, 4'hC, 32'h1006, 0,            0, 1, 32'hDEADBEEF, 1, 0, 0,            0, 0, 32'h1004,   0, 4'hC, 0));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 1, 32'hDEADBEEF, 0, 0, 32'h1004,   0, 4'hC, 0));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 0, 32'hDEADBEEF, 0, 0, 32'h1004,   0, 4'hC, 0));
    // store, ready held low for 4 REQ cycles, write ack carries junk data
    tbl.push_back(mk(1, 1, 4'h4, 32'h2000, 32'h00AB0000, 0, 0, 0,            1, 0, 32'hDEADBEEF, 0, 0, 32'h1004,   0, 4'hC, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 1, 4'h4, 32'h2000, 32'h00AB0000, 0, 0, 0,          1, 0, 32'hDEADBEEF, 0, 1, 32'h2000,   1, 4'h4, 32'h00AB0000));
    tbl.push_back(mk(1, 1, 4'h4, 32'h2000, 32'h00AB0000, 1, 0, 0,            1, 0, 32'hDEADBEEF, 0, 1, 32'h2000,   1, 4'h4, 32'h00AB0000));
    tbl.push_back(mk(1, 1, 4'h4, 32'h2000, 32'h00AB0000, 0, 1, 32'hCAFEF00D, 1, 0, 32'hDEADBEEF, 0, 0, 32'h2000,   1, 4'h4, 32'h00AB0000));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 1, 32'hDEADBEEF, 0, 0, 32'h2000,   1, 4'h4, 32'h00AB0000));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 0, 32'hDEADBEEF, 0, 0, 32'h2000,   1, 4'h4, 32'h00AB0000));
    // fast path: ready and response in the same REQ cycle
    tbl.push_back(mk(1, 0, 4'hF, 32'h3008, 0,            0, 0, 0,            1, 0, 32'hDEADBEEF, 0, 0, 32'h2000,   1, 4'h4, 32'h00AB0000));
    tbl.push_back(mk(1, 0, 4'hF, 32'h3008, 0,            1, 1, 32'h12345678, 1, 0, 32'hDEADBEEF, 0, 1, 32'h3008,   0, 4'hF, 0));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 1, 32'h12345678, 0, 0, 32'h3008,   0, 4'hF, 0));
    // back-to-back loads, request held through DONE, then a stray response in IDLE
    tbl.push_back(mk(1, 0, 4'hF, 32'h4000, 0,            0, 0, 0,            1, 0, 32'h12345678, 0, 0, 32'h3008,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4000, 0,            1, 1, 32'h11111111, 1, 0, 32'h12345678, 0, 1, 32'h4000,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4000, 0,            0, 0, 0,            0, 1, 32'h11111111, 0, 0, 32'h4000,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4004, 0,            0, 0, 0,            1, 0, 32'h11111111, 0, 0, 32'h4000,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4004, 0,            1, 0, 0,            1, 0, 32'h11111111, 0, 1, 32'h4004,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4004, 0,            0, 1, 32'h22222222, 1, 0, 32'h11111111, 0, 0, 32'h4004,   0, 4'hF, 0));
    tbl.push_back(mk(1, 0, 4'hF, 32'h4004, 0,            0, 0, 0,            0, 1, 32'h22222222, 0, 0, 32'h4004,   0, 4'hF, 0));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 1, 32'h99999999, 0, 0, 32'h22222222, 0, 0, 32'h4004,   0, 4'hF, 0));
    tbl.push_back(mk(0, 0, 0,    0,        0,            0, 0, 0,            0, 0, 32'h22222222, 0, 0, 32'h4004,   0, 4'hF, 0));

    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_row("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply_row($sformatf("vec%0d", i), tbl[i]);

    // timeout: no ready, no response; DONE after exactly 8 REQ cycles
    apply_row("to.idle", mk(1, 0, 4'hF, 32'h5000, 0, 0, 0, 0, 1, 0, 32'h22222222, 0, 0, 32'h4004, 0, 4'hF, 0));
    for (int i = 0; i < 8; i++)
      apply_row($sformatf("to.req%0d", i),
                mk(1, 0, 4'hF, 32'h5000, 0, 0, 0, 0, 1, 0, 32'h22222222, 0, 1, 32'h5000, 0, 4'hF, 0));
    apply_row("to.done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h5000, 0, 4'hF, 0));
    apply_row("sticky.idle", mk(1, 0, 4'hF, 32'h5010, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h5000, 0, 4'hF, 0));
    apply_row("sticky.req", mk(1, 0, 4'hF, 32'h5010, 0, 1, 1, 32'hA5A5A5A5, 1, 0, 0, 1, 1, 32'h5010, 0, 4'hF, 0));
    apply_row("sticky.done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 1, 0, 32'h5010, 0, 4'hF, 0));

    // reset while in WAIT, then a late response two cycles later
    apply_row("rw.idle", mk(1, 0, 4'hF, 32'h6000, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 0, 32'h5010, 0, 4'hF, 0));
    apply_row("rw.req", mk(1, 0, 4'hF, 32'h6000, 0, 1, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 1, 32'h6000, 0, 4'hF, 0));
    rst = 1'b1;
    apply_row("rw.wait", mk(1, 0, 4'hF, 32'h6000, 0, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 0, 32'h6000, 0, 4'hF, 0));
    rst = 1'b0;
    apply_row("rw.after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_row("rw.late", mk(0, 0, 0, 0, 0, 0, 1, 32'h77777777, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_row("rw.quiet", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_row("rw.new_idle", mk(1, 0, 4'h3, 32'h7006, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_row("rw.new_req", mk(1, 0, 4'h3, 32'h7006, 0, 1, 1, 32'h0BADF00D, 1, 0, 0, 0, 1, 32'h7004, 0, 4'h3, 0));
    apply_row("rw.new_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0, 0, 32'h7004, 0, 4'h3, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
